fp_wb_stage: RTL and testbench

FP_WB_STAGE -- requirements
Module: fp_wb_stage

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fp_wb_fifo.sv | 76 +++++++
 rtl/fp_wb_stage.sv | 86 ++++++++
 tb/tb_fp_wb_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP definitions: widths, fflags bit positions and the write-back entry.
package fpu_pkg;

   localparam int FLEN     = 32;
   localparam int FREG_W   = 5;
   localparam int FFLAGS_W = 5;

   // Bit positions inside an fflags vector {NV,DZ,OF,UF,NX}
   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   // One buffered result waiting for the FP register-file write port
   typedef struct packed {
      logic [FLEN-1:0]     data;
      logic [FREG_W-1:0]   rd;
      logic [FFLAGS_W-1:0] flags;
   } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// DEPTH-entry synchronous FIFO of write-back entries with flush.
// Push and pop may happen on the same edge; flush wins over both.
module fp_wb_fifo
   import fpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  fp_wb_entry_t               push_entry_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output fp_wb_entry_t               head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   fp_wb_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Explicit wrap so non-power-of-two depths would also stay in range
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Next-state for pointers and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; cleared on reset so the head is never X
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i && !flush_i) begin
         mem_q[wr_ptr_q] <= push_entry_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fp_wb_stage.sv
// FP write-back stage: arbitrates fast and slow FP results into a small
// buffer and drains it in order through the FP register-file write port.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds data stable until that edge. Readies depend
// only on buffer occupancy, flush and (for fast) slow_valid, never on
// rf_grant, so a pop in the same cycle cannot make room for a new result.
module fp_wb_stage
   import fpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fast_valid,
   output logic                fast_ready,
   input  logic [FLEN-1:0]     fast_data,
   input  logic [FREG_W-1:0]   fast_rd,
   input  logic                slow_valid,
   output logic                slow_ready,
   input  logic [FLEN-1:0]     slow_data,
   input  logic [FREG_W-1:0]   slow_rd,
   input  logic [FFLAGS_W-1:0] slow_flags,
   input  logic                flush,
   input  logic                rf_grant,
   output logic                rf_we,
   output logic [FREG_W-1:0]   rf_waddr,
   output logic [FLEN-1:0]     rf_wdata,
   output logic [FFLAGS_W-1:0] fflags_set,
   output logic                busy
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   fp_wb_entry_t     push_entry;
   fp_wb_entry_t     head;
   logic [CNT_W-1:0] count;
   logic             slow_fire;
   logic             fast_fire;
   logic             push;
   logic             has_entry;

   assign has_entry = (count != '0);

   // Accept side: slow wins a tie, so at most one result enters per cycle
   always_comb begin
      slow_ready = rst_n && (count < CNT_W'(DEPTH)) && !flush;
      fast_ready = slow_ready && !slow_valid;
      slow_fire  = slow_valid && slow_ready;
      fast_fire  = fast_valid && fast_ready;
      push       = slow_fire || fast_fire;
      push_entry = '0;
      if (slow_fire) begin
         push_entry.data  = slow_data;
         push_entry.rd    = slow_rd;
         push_entry.flags = slow_flags;
      end else begin
         push_entry.data  = fast_data;
         push_entry.rd    = fast_rd;
         push_entry.flags = '0;
      end
   end

   // Write side: drain the head whenever the port is granted
   always_comb begin
      rf_we      = rst_n && has_entry && rf_grant && !flush;
      rf_waddr   = head.rd;
      rf_wdata   = head.data;
      fflags_set = rf_we ? head.flags : '0;
      busy       = rst_n && has_entry;
   end

   fp_wb_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (rf_we),
      .flush_i      (flush),
      .head_o       (head),
      .count_o      (count)
   );

endmodule

// File: tb/tb_fp_wb_stage.sv
// Bench for fp_wb_stage: directed scenarios plus randomized traffic checked
// against a queue model of the write-back buffer.
module tb_fp_wb_stage;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fast_valid, fast_ready;
   logic [31:0] fast_data;
   logic [4:0]  fast_rd;
   logic        slow_valid, slow_ready;
   logic [31:0] slow_data;
   logic [4:0]  slow_rd, slow_flags;
   logic        flush, rf_grant, rf_we;
   logic [4:0]  rf_waddr, fflags_set;
   logic [31:0] rf_wdata;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   // Model: entries packed as {data[41:10], rd[9:5], flags[4:0]}
   logic [41:0] exp_q[$];

   fp_wb_stage #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .fast_valid(fast_valid), .fast_ready(fast_ready),
      .fast_data(fast_data), .fast_rd(fast_rd),
      .slow_valid(slow_valid), .slow_ready(slow_ready),
      .slow_data(slow_data), .slow_rd(slow_rd), .slow_flags(slow_flags),
      .flush(flush), .rf_grant(rf_grant),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fflags_set(fflags_set), .busy(busy)
   );

   // Clock
   always #5 clk = ~clk;

   // Global time limit
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fast_valid = 0; fast_data = '0; fast_rd = '0;
      slow_valid = 0; slow_data = '0; slow_rd = '0; slow_flags = '0;
      flush = 0; rf_grant = 0;
   endtask

   task automatic drive_fast(input logic [31:0] d, input logic [4:0] rd);
      fast_valid = 1; fast_data = d; fast_rd = rd;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      tick(); tick();
      @(negedge clk);
      checks += 7;
      if (rf_we !== 1'b0)      begin failures++; $display("FAIL reset_we: got %b expected 0", rf_we); end
      if (fflags_set !== 5'd0) begin failures++; $display("FAIL reset_fflags: got %h expected 0", fflags_set); end
      if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (rf_waddr !== 5'd0)   begin failures++; $display("FAIL reset_waddr: got %h expected 0", rf_waddr); end
      if (rf_wdata !== 32'd0)  begin failures++; $display("FAIL reset_wdata: got %h expected 0", rf_wdata); end
      if (slow_ready !== 1'b0) begin failures++; $display("FAIL reset_sready: got %b expected 0", slow_ready); end
      if (fast_ready !== 1'b0) begin failures++; $display("FAIL reset_fready: got %b expected 0", fast_ready); end
      rst_n = 1;
      tick();
      @(negedge clk);
      checks += 2;
      if (slow_ready !== 1'b1) begin failures++; $display("FAIL post_reset_sready: got %b expected 1", slow_ready); end
      if (fast_ready !== 1'b1) begin failures++; $display("FAIL post_reset_fready: got %b expected 1", fast_ready); end
      tick();
   endtask

   task automatic test_single_fast();
      rf_grant = 1;
      drive_fast(32'hBF800000, 5'd3);
      @(negedge clk);
      checks += 2;
      if (fast_ready !== 1'b1) begin failures++; $display("FAIL single_fready: got %b expected 1", fast_ready); end
      if (rf_we !== 1'b0)      begin failures++; $display("FAIL single_no_bypass: got %b expected 0", rf_we); end
      tick();
      fast_valid = 0;
      @(negedge clk);
      checks += 4;
      if (rf_we !== 1'b1)             begin failures++; $display("FAIL single_we: got %b expected 1", rf_we); end
      if (rf_waddr !== 5'd3)          begin failures++; $display("FAIL single_waddr: got %0d expected 3", rf_waddr); end
      if (rf_wdata !== 32'hBF800000)  begin failures++; $display("FAIL single_wdata: got %h expected bf800000", rf_wdata); end
      if (fflags_set !== 5'd0)        begin failures++; $display("FAIL single_fflags: got %h expected 0", fflags_set); end
      tick();
      @(negedge clk);
      checks += 2;
      if (rf_we !== 1'b0) begin failures++; $display("FAIL single_empty_we: got %b expected 0", rf_we); end
      if (busy !== 1'b0)  begin failures++; $display("FAIL single_empty_busy: got %b expected 0", busy); end
      rf_grant = 0;
      tick();
   endtask

   task automatic test_tie();
      slow_valid = 1; slow_data = 32'h40490FDB; slow_rd = 5'd7; slow_flags = 5'b00001;
      drive_fast(32'h3F800000, 5'd2);
      @(negedge clk);
      checks += 2;
      if (slow_ready !== 1'b1) begin failures++; $display("FAIL tie_sready: got %b expected 1", slow_ready); end
      if (fast_ready !== 1'b0) begin failures++; $display("FAIL tie_fready: got %b expected 0", fast_ready); end
      tick();
      slow_valid = 0;
      @(negedge clk);
      checks++;
      if (fast_ready !== 1'b1) begin failures++; $display("FAIL tie_fready_next: got %b expected 1", fast_ready); end
      tick();
      fast_valid = 0; rf_grant = 1;
      @(negedge clk);
      checks += 4;
      if (rf_we !== 1'b1)            begin failures++; $display("FAIL tie_we1: got %b expected 1", rf_we); end
      if (rf_waddr !== 5'd7)         begin failures++; $display("FAIL tie_waddr1: got %0d expected 7", rf_waddr); end
      if (rf_wdata !== 32'h40490FDB) begin failures++; $display("FAIL tie_wdata1: got %h expected 40490fdb", rf_wdata); end
      if (fflags_set !== 5'b00001)   begin failures++; $display("FAIL tie_fflags1: got %b expected 00001", fflags_set); end
      tick();
      @(negedge clk);
      checks += 4;
      if (rf_we !== 1'b1)            begin failures++; $display("FAIL tie_we2: got %b expected 1", rf_we); end
      if (rf_waddr !== 5'd2)         begin failures++; $display("FAIL tie_waddr2: got %0d expected 2", rf_waddr); end
      if (rf_wdata !== 32'h3F800000) begin failures++; $display("FAIL tie_wdata2: got %h expected 3f800000", rf_wdata); end
      if (fflags_set !== 5'd0)       begin failures++; $display("FAIL tie_fflags2: got %b expected 00000", fflags_set); end
      tick();
      rf_grant = 0;
   endtask

   task automatic test_backpressure();
      logic [4:0] exp_rd [3];
      exp_rd[0] = 5'd10; exp_rd[1] = 5'd11; exp_rd[2] = 5'd12;
      rf_grant = 0;
      drive_fast(32'h0000_0010, 5'd10); tick();
      drive_fast(32'h0000_0011, 5'd11); tick();
      drive_fast(32'h0000_0012, 5'd12);
      @(negedge clk);
      checks += 3;
      if (fast_ready !== 1'b0) begin failures++; $display("FAIL bp_fready_full: got %b expected 0", fast_ready); end
      if (slow_ready !== 1'b0) begin failures++; $display("FAIL bp_sready_full: got %b expected 0", slow_ready); end
      if (rf_we !== 1'b0)      begin failures++; $display("FAIL bp_no_grant_we: got %b expected 0", rf_we); end
      tick();
      rf_grant = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks += 3;
         if (rf_we !== 1'b1)      begin failures++; $display("FAIL bp_we%0d: got %b expected 1", i, rf_we); end
         if (rf_waddr !== exp_rd[i]) begin failures++; $display("FAIL bp_waddr%0d: got %0d expected %0d", i, rf_waddr, exp_rd[i]); end
         if (rf_wdata !== {27'd0, exp_rd[i] + 5'd6}) begin failures++; $display("FAIL bp_wdata%0d: got %h expected %h", i, rf_wdata, {27'd0, exp_rd[i] + 5'd6}); end
         tick();
         if (i == 1) fast_valid = 0;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL bp_drained: got %b expected 0", busy); end
      rf_grant = 0;
      tick();
   endtask

   task automatic test_full_pop();
      rf_grant = 0;
      drive_fast(32'hA0, 5'd20); tick();
      drive_fast(32'hA1, 5'd21); tick();
      drive_fast(32'hA2, 5'd22); rf_grant = 1;
      @(negedge clk);
      checks += 3;
      if (fast_ready !== 1'b0) begin failures++; $display("FAIL fp_fready_full: got %b expected 0", fast_ready); end
      if (rf_we !== 1'b1)      begin failures++; $display("FAIL fp_we: got %b expected 1", rf_we); end
      if (rf_waddr !== 5'd20)  begin failures++; $display("FAIL fp_waddr0: got %0d expected 20", rf_waddr); end
      tick();
      @(negedge clk);
      checks += 2;
      if (fast_ready !== 1'b1) begin failures++; $display("FAIL fp_fready_after_pop: got %b expected 1", fast_ready); end
      if (rf_waddr !== 5'd21)  begin failures++; $display("FAIL fp_waddr1: got %0d expected 21", rf_waddr); end
      tick();
      fast_valid = 0;
      @(negedge clk);
      checks += 2;
      if (rf_we !== 1'b1)         begin failures++; $display("FAIL fp_we2: got %b expected 1", rf_we); end
      if (rf_wdata !== 32'hA2)    begin failures++; $display("FAIL fp_wdata2: got %h expected a2", rf_wdata); end
      tick();
      rf_grant = 0;
   endtask

   task automatic test_flush();
      drive_fast(32'hF0, 5'd1); tick();
      drive_fast(32'hF1, 5'd2); tick();
      fast_valid = 0; rf_grant = 1; flush = 1;
      @(negedge clk);
      checks += 3;
      if (rf_we !== 1'b0)      begin failures++; $display("FAIL flush_we: got %b expected 0", rf_we); end
      if (fflags_set !== 5'd0) begin failures++; $display("FAIL flush_fflags: got %h expected 0", fflags_set); end
      if (slow_ready !== 1'b0) begin failures++; $display("FAIL flush_sready: got %b expected 0", slow_ready); end
      tick();
      flush = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks += 2;
         if (busy !== 1'b0)  begin failures++; $display("FAIL flush_busy%0d: got %b expected 0", i, busy); end
         if (rf_we !== 1'b0) begin failures++; $display("FAIL flush_late_we%0d: got %b expected 0", i, rf_we); end
         tick();
      end
      rf_grant = 0;
   endtask

   task automatic test_reset_mid();
      slow_valid = 1; slow_data = 32'h1234; slow_rd = 5'd9; slow_flags = 5'b10100; tick();
      slow_data = 32'h5678; slow_rd = 5'd10; tick();
      slow_valid = 0; rf_grant = 1; rst_n = 0;
      tick();
      @(negedge clk);
      checks += 5;
      if (rf_we !== 1'b0)      begin failures++; $display("FAIL rmid_we: got %b expected 0", rf_we); end
      if (busy !== 1'b0)       begin failures++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      if (fflags_set !== 5'd0) begin failures++; $display("FAIL rmid_fflags: got %h expected 0", fflags_set); end
      if (rf_waddr !== 5'd0)   begin failures++; $display("FAIL rmid_waddr: got %h expected 0", rf_waddr); end
      if (rf_wdata !== 32'd0)  begin failures++; $display("FAIL rmid_wdata: got %h expected 0", rf_wdata); end
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         checks++;
         if (rf_we !== 1'b0) begin failures++; $display("FAIL rmid_after_we%0d: got %b expected 0", i, rf_we); end
      end
      rf_grant = 0;
      tick();
   endtask

   task automatic test_random();
      bit          e_sr, e_fr, e_we, s_acc, f_acc;
      logic [41:0] head;
      exp_q.delete();
      s_acc = 0; f_acc = 0;
      for (int c = 0; c < 4000; c++) begin
         // Producers hold an offered result until it is taken
         if (!slow_valid || s_acc) begin
            slow_valid = ($urandom_range(0, 2) == 0);
            slow_data  = $urandom;
            slow_rd    = 5'($urandom_range(0, 31));
            slow_flags = 5'($urandom_range(0, 31));
         end
         if (!fast_valid || f_acc) begin
            fast_valid = ($urandom_range(0, 1) == 1);
            fast_data  = $urandom;
            fast_rd    = 5'($urandom_range(0, 31));
         end
         rf_grant = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 39) == 0);
         rst_n    = ($urandom_range(0, 299) != 0);
         @(negedge clk);
         e_sr = rst_n && (exp_q.size() < DEPTH) && !flush;
         e_fr = e_sr && !slow_valid;
         e_we = rst_n && (exp_q.size() > 0) && rf_grant && !flush;
         if (rst_n) begin
            checks += 4;
            if (slow_ready !== e_sr) begin failures++; $display("FAIL rnd_sready c%0d: got %b expected %b", c, slow_ready, e_sr); end
            if (fast_ready !== e_fr) begin failures++; $display("FAIL rnd_fready c%0d: got %b expected %b", c, fast_ready, e_fr); end
            if (rf_we !== e_we)      begin failures++; $display("FAIL rnd_we c%0d: got %b expected %b", c, rf_we, e_we); end
            if (busy !== (exp_q.size() != 0)) begin failures++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, exp_q.size() != 0); end
         end
         if (e_we) begin
            head = exp_q[0];
            checks += 3;
            if (rf_waddr !== head[9:5])    begin failures++; $display("FAIL rnd_waddr c%0d: got %0d expected %0d", c, rf_waddr, head[9:5]); end
            if (rf_wdata !== head[41:10])  begin failures++; $display("FAIL rnd_wdata c%0d: got %h expected %h", c, rf_wdata, head[41:10]); end
            if (fflags_set !== head[4:0])  begin failures++; $display("FAIL rnd_fflags c%0d: got %b expected %b", c, fflags_set, head[4:0]); end
         end else begin
            checks++;
            if (fflags_set !== 5'd0) begin failures++; $display("FAIL rnd_fflags_idle c%0d: got %b expected 0", c, fflags_set); end
         end
         @(posedge clk);
         s_acc = slow_valid && e_sr;
         f_acc = fast_valid && e_fr;
         if (!rst_n || flush) begin
            exp_q.delete();
         end else begin
            if (e_we) void'(exp_q.pop_front());
            if (s_acc)      exp_q.push_back({slow_data, slow_rd, slow_flags});
            else if (f_acc) exp_q.push_back({fast_data, fast_rd, 5'd0});
         end
         #1;
      end
      idle_inputs();
      rst_n = 1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      test_reset();
      test_single_fast();
      test_tie();
      test_backpressure();
      test_full_pop();
      test_flush();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
